// File: rtl/seg_msg_arbiter_if.sv
// seg_msg_arbiter_if: request/digit bus between message sources and the display arbiter.
interface seg_msg_arbiter_if;
    logic [2:0]  req;
    logic [47:0] req_digits;
    logic [15:0] digit_out;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [2:0]  grant_ack;
    modport master (output req, req_digits, input digit_out, grant_valid, grant_id, grant_ack);
    modport slave  (input req, req_digits, output digit_out, grant_valid, grant_id, grant_ack);
endinterface

// File: rtl/seg_msg_arbiter.sv
// seg_msg_arbiter: priority owner selection with minimum hold for the 4-digit display.
// Define SEG_ARB_BLINK_EN to blink the error countdown (source 0).
module seg_msg_arbiter #(
    parameter int HOLD_CYC  = 50_000_000,
    parameter int BLINK_CYC = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    seg_msg_arbiter_if.slave bus
);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYC - 1);
    typedef enum logic {IDLE, SHOW} state_t;
    state_t      r_state, w_state;
    logic [1:0]  r_owner, w_owner, w_win;
    logic [HW-1:0] r_hold, w_hold;
    logic [15:0] r_trk, w_trk, r_dout, w_win_sl, w_own_sl;
    logic [2:0]  r_ack, w_ack;
    logic        r_valid, w_grant, w_any, w_own_req, w_blank;
    assign w_win     = bus.req[0] ? 2'd0 : bus.req[1] ? 2'd1 : 2'd2;
    assign w_any     = |bus.req;
    assign w_own_req = bus.req[r_owner];
    assign w_win_sl  = bus.req_digits[{w_win, 4'b0} +: 16];
    assign w_own_sl  = bus.req_digits[{r_owner, 4'b0} +: 16];
    // A new grant covers idle pickup, preemption by a higher source, and handover after hold expiry.
    always_comb begin
        w_grant = w_any && (r_state == IDLE || w_win < r_owner || (r_hold == '0 && !w_own_req));
        w_state = (w_grant || (r_state == SHOW && (r_hold != '0 || w_own_req))) ? SHOW : IDLE;
        w_owner = w_grant ? w_win : (w_state == SHOW ? r_owner : 2'd0);
        w_hold  = w_grant ? HOLD_LD : (r_hold != '0 ? r_hold - HW'(1) : '0);
        w_ack   = w_grant ? 3'b001 << w_win : 3'b000;
        w_trk   = w_grant ? w_win_sl : w_state == IDLE ? 16'hFFFF : w_own_req ? w_own_sl : r_trk;
    end
`ifdef SEG_ARB_BLINK_EN
    localparam int BW = BLINK_CYC > 1 ? $clog2(BLINK_CYC) : 1;
    logic [BW-1:0] r_bcnt;
    logic          r_phase, w_wrap, w_phase;
    assign w_wrap  = r_bcnt == BW'(BLINK_CYC - 1);
    assign w_phase = w_ack[0] ? 1'b0 : r_phase ^ w_wrap;
    assign w_blank = w_state == SHOW && w_owner == 2'd0 && w_phase;
    // Counter restarts with the phase on a fresh error grant so every blink period is full length.
    always_ff @(posedge clk) begin
        if (rst || w_ack[0]) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else begin
            r_bcnt  <= w_wrap ? '0 : r_bcnt + BW'(1);
            r_phase <= r_phase ^ w_wrap;
        end
    end
`else
    assign w_blank = 1'b0 && (BLINK_CYC > 0);
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= 2'd0;
            r_hold  <= '0;
            r_trk   <= 16'hFFFF;
            r_dout  <= 16'hFFFF;
            r_valid <= 1'b0;
            r_ack   <= 3'b000;
        end else begin
            r_state <= w_state;
            r_owner <= w_owner;
            r_hold  <= w_hold;
            r_trk   <= w_trk;
            r_dout  <= w_blank ? 16'hFFFF : w_trk;
            r_valid <= w_state == SHOW;
            r_ack   <= w_ack;
        end
    end
    assign bus.digit_out   = r_dout;
    assign bus.grant_valid = r_valid;
    assign bus.grant_id    = r_owner;
    assign bus.grant_ack   = r_ack;
endmodule

// File: tb/tb_seg_msg_arbiter.sv
// tb_seg_msg_arbiter: scenario tasks driving the arbiter against a cycle-level reference scoreboard.
module tb_seg_msg_arbiter;
    localparam int HOLD  = 8;
    localparam int BLINK = 4;
    localparam logic [21:0] IDLE_OBS = {1'b0, 2'd0, 3'b000, 16'hFFFF};
    logic clk = 1'b0;
    logic rst = 1'b1;
    seg_msg_arbiter_if bus ();
    seg_msg_arbiter #(.HOLD_CYC(HOLD), .BLINK_CYC(BLINK)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    logic [21:0] w_obs;
    assign w_obs = {bus.grant_valid, bus.grant_id, bus.grant_ack, bus.digit_out};
    logic [21:0] sb[$];
    logic [21:0] exp_v;
    int n_chk = 0;
    int n_err = 0;
    bit m_show, m_phase;
    int m_owner, m_hold, m_bcnt;
    logic [15:0] m_trk;
    // Reference behaviour written from the rule list; one expected word per clock edge.
    task automatic drive(input logic r, input logic [2:0] q, input logic [47:0] d);
        int win;
        bit g, blank;
        logic [2:0] ack;
        rst = r;
        bus.req = q;
        bus.req_digits = d;
        g = 0;
        ack = 3'b000;
        if (r) begin
            m_show = 0; m_owner = 0; m_hold = 0; m_trk = 16'hFFFF; m_bcnt = 0; m_phase = 0;
        end else begin
            win = q[0] ? 0 : q[1] ? 1 : 2;
            if (!m_show) g = |q;
            else if (|q && win < m_owner) g = 1;
            else if (m_hold > 0) begin
                m_hold--;
                if (q[m_owner]) m_trk = d[m_owner*16 +: 16];
            end else if (q[m_owner]) m_trk = d[m_owner*16 +: 16];
            else if (|q) g = 1;
            else begin
                m_show = 0; m_owner = 0; m_trk = 16'hFFFF;
            end
            if (g) begin
                m_show = 1; m_owner = win; m_hold = HOLD - 1; m_trk = d[win*16 +: 16];
                ack = 3'b001 << win;
            end
            if (g && win == 0) begin
                m_bcnt = 0; m_phase = 0;
            end else if (m_bcnt == BLINK - 1) begin
                m_bcnt = 0; m_phase = !m_phase;
            end else m_bcnt++;
        end
`ifdef SEG_ARB_BLINK_EN
        blank = m_show && m_owner == 0 && m_phase;
`else
        blank = 0;
`endif
        sb.push_back({m_show, 2'(m_owner), ack, blank ? 16'hFFFF : m_trk});
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        logic [47:0] d = 48'h3333_2222_1234;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b111, d);
            exp_v = sb.pop_front();
            n_chk++;
            if (w_obs !== exp_v) begin n_err++; $display("FAIL reset_sb c%0d: got %h exp %h", i, w_obs, exp_v); end
            n_chk++;
            if (w_obs !== IDLE_OBS) begin n_err++; $display("FAIL reset_state c%0d: got %h exp %h", i, w_obs, IDLE_OBS); end
        end
        drive(1'b0, 3'b111, d);
        exp_v = sb.pop_front();
        n_chk++;
        if (w_obs !== {1'b1, 2'd0, 3'b001, 16'h1234}) begin n_err++; $display("FAIL reset_release: got %h exp %h", w_obs, {1'b1, 2'd0, 3'b001, 16'h1234}); end
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 3'b000, d);
            exp_v = sb.pop_front();
            n_chk++;
            if (w_obs !== exp_v) begin n_err++; $display("FAIL reset_drain c%0d: got %h exp %h", i, w_obs, exp_v); end
        end
        n_chk++;
        if (w_obs !== IDLE_OBS) begin n_err++; $display("FAIL reset_idle: got %h exp %h", w_obs, IDLE_OBS); end
    endtask
    task automatic test_hold();
        logic [47:0] d = {16'hBFFF, 32'h0};
        int acks = 0, shows = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, i == 0 ? 3'b100 : 3'b000, d);
            exp_v = sb.pop_front();
            n_chk++;
            if (w_obs !== exp_v) begin n_err++; $display("FAIL hold c%0d: got %h exp %h", i, w_obs, exp_v); end
            acks += int'(bus.grant_ack == 3'b100);
            shows += int'(bus.digit_out == 16'hBFFF && bus.grant_valid && bus.grant_id == 2'd2);
        end
        n_chk++;
        if (acks != 1) begin n_err++; $display("FAIL hold_acks: got %0d exp 1", acks); end
        n_chk++;
        if (shows != HOLD) begin n_err++; $display("FAIL hold_len: got %0d exp %0d", shows, HOLD); end
        n_chk++;
        if (w_obs !== IDLE_OBS) begin n_err++; $display("FAIL hold_idle: got %h exp %h", w_obs, IDLE_OBS); end
    endtask
    task automatic test_preempt();
        logic [47:0] d = {16'h2FF2, 16'h0000, 16'hF15F};
        for (int i = 0; i < 33; i++) begin
            drive(1'b0, i < 4 ? 3'b100 : i < 24 ? 3'b101 : i == 24 ? 3'b100 : 3'b000, d);
            exp_v = sb.pop_front();
            n_chk++;
            if (w_obs !== exp_v) begin n_err++; $display("FAIL preempt c%0d: got %h exp %h", i, w_obs, exp_v); end
            if (i == 4) begin
                n_chk++;
                if (w_obs !== {1'b1, 2'd0, 3'b001, 16'hF15F}) begin n_err++; $display("FAIL preempt_take: got %h exp %h", w_obs, {1'b1, 2'd0, 3'b001, 16'hF15F}); end
            end
            if (i == 24) begin
                n_chk++;
                if (w_obs !== {1'b1, 2'd2, 3'b100, 16'h2FF2}) begin n_err++; $display("FAIL preempt_regain: got %h exp %h", w_obs, {1'b1, 2'd2, 3'b100, 16'h2FF2}); end
            end
        end
        n_chk++;
        if (w_obs !== IDLE_OBS) begin n_err++; $display("FAIL preempt_idle: got %h exp %h", w_obs, IDLE_OBS); end
    endtask
    task automatic test_track();
        drive(1'b0, 3'b010, {16'h0, 16'h1FF2, 16'h0});
        exp_v = sb.pop_front();
        n_chk++;
        if (w_obs !== {1'b1, 2'd1, 3'b010, 16'h1FF2}) begin n_err++; $display("FAIL track_grant: got %h exp %h", w_obs, {1'b1, 2'd1, 3'b010, 16'h1FF2}); end
        drive(1'b0, 3'b010, {16'h0, 16'h1FF3, 16'h0});
        exp_v = sb.pop_front();
        n_chk++;
        if (w_obs !== {1'b1, 2'd1, 3'b000, 16'h1FF3}) begin n_err++; $display("FAIL track_step: got %h exp %h", w_obs, {1'b1, 2'd1, 3'b000, 16'h1FF3}); end
        drive(1'b0, 3'b010, {16'h0, 16'h1FF3, 16'h0});
        exp_v = sb.pop_front();
        n_chk++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL track_sb: got %h exp %h", w_obs, exp_v); end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 3'b000, {16'h0, 16'h1234, 16'h0});
            exp_v = sb.pop_front();
            n_chk++;
            if (w_obs !== exp_v) begin n_err++; $display("FAIL track_drop_sb c%0d: got %h exp %h", i, w_obs, exp_v); end
            n_chk++;
            if (w_obs !== (i < 5 ? {1'b1, 2'd1, 3'b000, 16'h1FF3} : IDLE_OBS)) begin
                n_err++; $display("FAIL track_frozen c%0d: got %h", i, w_obs);
            end
        end
    endtask
    task automatic test_simul();
        logic [47:0] d = {16'h2222, 16'h1111, 16'h0000};
        for (int i = 0; i < 23; i++) begin
            drive(1'b0, i < 13 ? 3'b110 : i == 13 ? 3'b100 : 3'b000, d);
            exp_v = sb.pop_front();
            n_chk++;
            if (w_obs !== exp_v) begin n_err++; $display("FAIL simul c%0d: got %h exp %h", i, w_obs, exp_v); end
            if (i == 0 || i == 12 || i == 13) begin
                n_chk++;
                if (w_obs !== (i == 0 ? {1'b1, 2'd1, 3'b010, 16'h1111} : i == 12 ? {1'b1, 2'd1, 3'b000, 16'h1111} : {1'b1, 2'd2, 3'b100, 16'h2222})) begin
                    n_err++; $display("FAIL simul_owner c%0d: got %h", i, w_obs);
                end
            end
        end
        n_chk++;
        if (w_obs !== IDLE_OBS) begin n_err++; $display("FAIL simul_idle: got %h exp %h", w_obs, IDLE_OBS); end
    endtask
    task automatic test_blink();
        logic [15:0] want;
        for (int k = 0; k < 29; k++) begin
            drive(1'b0, k < 20 ? 3'b001 : 3'b000, {32'h0, 16'hF09F});
            exp_v = sb.pop_front();
            n_chk++;
            if (w_obs !== exp_v) begin n_err++; $display("FAIL blink_sb c%0d: got %h exp %h", k, w_obs, exp_v); end
            if (k < 20) begin
`ifdef SEG_ARB_BLINK_EN
                want = ((k / BLINK) % 2) != 0 ? 16'hFFFF : 16'hF09F;
`else
                want = 16'hF09F;
`endif
                n_chk++;
                if (w_obs !== {1'b1, 2'd0, k == 0 ? 3'b001 : 3'b000, want}) begin
                    n_err++; $display("FAIL blink c%0d: got %h exp digits %h", k, w_obs, want);
                end
            end
        end
        n_chk++;
        if (w_obs !== IDLE_OBS) begin n_err++; $display("FAIL blink_idle: got %h exp %h", w_obs, IDLE_OBS); end
    endtask
    initial begin
        bus.req = 3'b000;
        bus.req_digits = '0;
        test_reset();
        test_hold();
        test_preempt();
        test_track();
        test_simul();
        test_blink();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
